buffer_tx_stream: RTL and testbench
===================================

Name: buffer_tx_stream

Overview:
Outbound packet buffer for the XVC microserver: the transmit-side counterpart of the inbound receive buffer.
- The processing side fills a packet by indexed word writes and commits it.
- A transmitter FSM streams committed packets, oldest first, over a valid/ready word interface with a last flag.
- Sits between the XVC command engine (producer) and the network send path (consumer).

Parameters:
DATA_WIDTH, 32, width of one buffer word
DEPTH, 16, max words per packet slot; power of two
SLOTS, 4, physical packet slots including the open write slot; at most SLOTS-1 committed packets

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write wr_data at wr_index in the open slot
wr_index  in  $clog2(DEPTH)+1  word index in the open slot
wr_data  in  DATA_WIDTH  word to store
wr_commit  in  1  close the open slot, queue it for transmit, open the next slot
wr_len  out  $clog2(DEPTH)+1  current length of the open slot
full  out  1  committed count == SLOTS-1
wr_overflow  out  1  one-cycle pulse: commit refused (full) or wr_index >= DEPTH
tx_data  out  DATA_WIDTH  current outbound word
tx_valid  out  1  tx_data is valid
tx_last  out  1  tx_data is the final word of the packet
tx_ready  in  1  consumer accepts the word
tx_len  out  $clog2(DEPTH)+1  length of the packet in transmission; valid while tx_valid
empty  out  1  no committed packets and FSM in IDLE

Behaviour:
Reset:
- Asserting reset immediately clears all pointers, counts and lengths.
- Outputs go to tx_valid=0, tx_last=0, tx_data=0, tx_len=0, wr_len=0, full=0, wr_overflow=0, empty=1.
- Reset mid-packet discards all slots, including the open slot and the packet in flight.

Write side:
- wr_en with wr_index < DEPTH stores the word.
- Open-slot length becomes max(len, wr_index+1). Out-of-order writes are legal; holes hold stale data.
- wr_en with wr_index >= DEPTH: no write, wr_overflow pulses.

Commit:
- wr_commit with len > 0 and not full: slot is queued, the write pointer advances modulo SLOTS, the new open slot has len 0.
- wr_commit with len == 0: no-op, no pulse.
- wr_commit while full: refused, open slot is kept intact, wr_overflow pulses.
- wr_en and wr_commit in the same cycle: the write lands in the slot being committed, and its length update is included.
- A commit in the same cycle as the final tx handshake while full is accepted, because the freed slot counts.

Transmitter FSM (IDLE, LOAD, SEND):
- IDLE -> LOAD when committed count > 0. Storage read has 1-cycle latency.
- LOAD -> SEND: tx_valid=1, word 0 presented, tx_len latched.
  - First tx_valid appears 2 cycles after the commit edge.
- SEND: on tx_valid & tx_ready, advance to the next word with no bubble (next word prefetched).
  - tx_data, tx_last and tx_len are held stable while tx_valid & !tx_ready.
- Final word: tx_last=1. Its handshake frees the slot (count-1, read pointer +1) and moves the FSM to IDLE.
  - tx_valid=0 for at least 1 cycle between packets.
- Transmitter pointers wrap modulo SLOTS. Word counter width is $clog2(DEPTH)+1 and compares against the latched tx_len.

Optional Feature:
BUFFER_TX_LEN_HEADER_EN:
- Defined: each packet is preceded by one header word, tx_data = tx_len zero-extended to DATA_WIDTH, with tx_last=0. The header uses the same handshake, followed by the data words; tx_last stays on the final data word.
- Undefined: data words only.

Test Plan:
- Write 300..307 at indices 0..7, commit; write 400..403 at 0..3, commit; tx_ready=1 -> tx_data 300..307 with tx_len=8 and tx_last on 307, ≥1 idle cycle, then 400..403 with tx_len=4 and tx_last on 403, then empty=1.
- Same traffic with tx_ready toggled 1-of-3 cycles -> identical word sequence, tx_data stable during every stall, no duplicated or dropped words.
- tx_ready=0, commit 3 one-word packets -> full=1; 4th commit -> wr_overflow pulse, open slot keeps its len. Then complete one packet -> full=0, retried commit accepted.
- Write index 5 then index 2 then commit -> wr_len=6, 6 words sent, last word is the index-5 data. Write index 16 (DEPTH=16) -> wr_overflow pulse, no length change. Commit with len 0 -> nothing sent.
- Assert reset during the 3rd word of a 4-word packet -> tx_valid=0 at once, empty=1, wr_len=0. A new 2-word packet sent cleanly after reset.
- With BUFFER_TX_LEN_HEADER_EN: commit 400..403 -> header word 4, then 400..403 with tx_last on 403.

Source files
------------

// File: rtl/buffer_tx_stream.sv
// ---------------------------------------------------------------------------
// buffer_tx_stream
//   Outbound packet buffer for the XVC microserver. The command engine fills
//   the open packet slot with indexed word writes and commits it; a small
//   transmitter FSM (IDLE -> LOAD -> SEND) streams committed packets, oldest
//   first, over a valid/ready word interface with a last flag.
//
//   Optional feature macro: BUFFER_TX_LEN_HEADER_EN
//     defined   : every packet is preceded by one header word carrying its
//                 length (zero-extended), sent with tx_last=0.
//     undefined : data words only.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   wr_en        in   write wr_data at wr_index in the open slot
//   wr_index     in   word index in the open slot ($clog2(DEPTH)+1 bits)
//   wr_data      in   word to store
//   wr_commit    in   close the open slot and queue it for transmit
//   wr_len       out  current length of the open slot
//   full         out  SLOTS-1 packets committed
//   wr_overflow  out  one-cycle pulse: commit refused or wr_index >= DEPTH
//   tx_data      out  current outbound word
//   tx_valid     out  tx_data is valid
//   tx_last      out  tx_data is the final word of the packet
//   tx_ready     in   consumer accepts the word
//   tx_len       out  length of the packet in transmission
//   empty        out  no committed packets and transmitter idle
// ---------------------------------------------------------------------------
module buffer_tx_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int SLOTS      = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [$clog2(DEPTH):0]       wr_index,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         wr_commit,
   output logic [$clog2(DEPTH):0]       wr_len,
   output logic                         full,
   output logic                         wr_overflow,
   output logic [DATA_WIDTH-1:0]        tx_data,
   output logic                         tx_valid,
   output logic                         tx_last,
   input  logic                         tx_ready,
   output logic [$clog2(DEPTH):0]       tx_len,
   output logic                         empty
);

   localparam int IW = $clog2(DEPTH) + 1;   // length / index width
   localparam int AW = $clog2(DEPTH);       // in-slot address width
   localparam int SW = $clog2(SLOTS);       // slot pointer width
   localparam int CW = $clog2(SLOTS) + 1;   // committed-count width

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

   logic [DATA_WIDTH-1:0] mem_r [SLOTS*DEPTH];
   logic [IW-1:0]         slot_len_r [SLOTS];
   logic [SW-1:0]         wptr_r;
   logic [SW-1:0]         rptr_r;
   logic [CW-1:0]         count_r;
   logic [IW-1:0]         wr_len_r;
   logic                  full_r;
   logic                  empty_r;
   logic                  wr_overflow_r;
   logic [1:0]            state_r;
   logic [IW-1:0]         rd_idx_r;
   logic [IW-1:0]         tx_len_r;
   logic [DATA_WIDTH-1:0] tx_data_r;
   logic                  tx_valid_r;
   logic                  tx_last_r;

   logic                  idx_ok_s;
   logic                  wr_do_s;
   logic [IW-1:0]         len_eff_s;
   logic                  release_s;
   logic                  commit_try_s;
   logic                  commit_ok_s;
   logic                  commit_ref_s;
   logic [CW-1:0]         count_nxt_s;
   logic [1:0]            state_nxt_s;
   logic [SW-1:0]         wptr_inc_s;
   logic [SW-1:0]         rptr_inc_s;

   // Write/commit decode; a same-cycle write is folded into the committed length.
   always_comb begin
      idx_ok_s     = (wr_index < IW'(DEPTH));
      wr_do_s      = wr_en & idx_ok_s;
      if (wr_do_s && ((wr_index + IW'(1)) > wr_len_r)) begin
         len_eff_s = wr_index + IW'(1);
      end else begin
         len_eff_s = wr_len_r;
      end
      // Final handshake frees a slot in this same cycle, so a commit while
      // full is still accepted when it coincides with it.
      release_s    = (state_r == ST_SEND) & tx_valid_r & tx_ready & tx_last_r;
      commit_try_s = wr_commit & (len_eff_s != '0);
      commit_ok_s  = commit_try_s & (~full_r | release_s);
      commit_ref_s = commit_try_s & ~commit_ok_s;
      wptr_inc_s   = (wptr_r == SW'(SLOTS - 1)) ? '0 : wptr_r + SW'(1);
      rptr_inc_s   = (rptr_r == SW'(SLOTS - 1)) ? '0 : rptr_r + SW'(1);
   end

   // Next committed count and transmitter state.
   always_comb begin
      if (commit_ok_s && !release_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (release_s && !commit_ok_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
      case (state_r)
         ST_IDLE: state_nxt_s = (count_r != '0) ? ST_LOAD : ST_IDLE;
         ST_LOAD: state_nxt_s = ST_SEND;
         ST_SEND: state_nxt_s = release_s ? ST_IDLE : ST_SEND;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Packet storage: plain synchronous write, slot selects the upper address bits.
   always_ff @(posedge clock) begin
      if (wr_do_s) begin
         mem_r[{wptr_r, wr_index[AW-1:0]}] <= wr_data;
      end
   end

   // Write-side pointers, lengths, counts and status flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) begin
            slot_len_r[i] <= '0;
         end
         wptr_r        <= '0;
         rptr_r        <= '0;
         count_r       <= '0;
         wr_len_r      <= '0;
         full_r        <= 1'b0;
         empty_r       <= 1'b1;
         wr_overflow_r <= 1'b0;
      end else begin
         wr_overflow_r <= commit_ref_s | (wr_en & ~idx_ok_s);
         if (commit_ok_s) begin
            slot_len_r[wptr_r] <= len_eff_s;
            wptr_r             <= wptr_inc_s;
            wr_len_r           <= '0;
         end else begin
            wr_len_r           <= len_eff_s;
         end
         if (release_s) begin
            rptr_r <= rptr_inc_s;
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CW'(SLOTS - 1));
         empty_r <= (count_nxt_s == '0) && (state_nxt_s == ST_IDLE);
      end
   end

   // Transmitter: LOAD presents the first word, SEND prefetches the next on each handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         rd_idx_r   <= '0;
         tx_len_r   <= '0;
         tx_data_r  <= '0;
         tx_valid_r <= 1'b0;
         tx_last_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_LOAD: begin
               tx_valid_r <= 1'b1;
               tx_len_r   <= slot_len_r[rptr_r];
`ifdef BUFFER_TX_LEN_HEADER_EN
               tx_data_r  <= DATA_WIDTH'(slot_len_r[rptr_r]);
               tx_last_r  <= 1'b0;
               rd_idx_r   <= '0;
`else
               tx_data_r  <= mem_r[{rptr_r, {AW{1'b0}}}];
               tx_last_r  <= (slot_len_r[rptr_r] == IW'(1));
               rd_idx_r   <= IW'(1);
`endif
            end
            ST_SEND: begin
               if (tx_valid_r && tx_ready) begin
                  if (tx_last_r) begin
                     tx_valid_r <= 1'b0;
                     tx_last_r  <= 1'b0;
                  end else begin
                     tx_data_r  <= mem_r[{rptr_r, rd_idx_r[AW-1:0]}];
                     tx_last_r  <= (rd_idx_r == (tx_len_r - IW'(1)));
                     rd_idx_r   <= rd_idx_r + IW'(1);
                  end
               end
            end
            default: begin
               tx_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign wr_len      = wr_len_r;
   assign full        = full_r;
   assign empty       = empty_r;
   assign wr_overflow = wr_overflow_r;
   assign tx_data     = tx_data_r;
   assign tx_valid    = tx_valid_r;
   assign tx_last     = tx_last_r;
   assign tx_len      = tx_len_r;

endmodule

// File: tb/tb_buffer_tx_stream.sv
// ---------------------------------------------------------------------------
// tb_buffer_tx_stream
//   Scoreboard bench for buffer_tx_stream. Expected words are queued when a
//   packet is committed and popped on every tx handshake; stalls, inter-packet
//   gaps, full/overflow behaviour and asynchronous reset are checked directly.
// ---------------------------------------------------------------------------
module tb_buffer_tx_stream;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int SLOTS = 4;
   localparam int IW    = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [IW-1:0] wr_index;
   logic [DW-1:0] wr_data;
   logic          wr_commit;
   logic [IW-1:0] wr_len;
   logic          full;
   logic          wr_overflow;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_last;
   logic          tx_ready = 1'b0;
   logic [IW-1:0] tx_len;
   logic          empty;

   buffer_tx_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SLOTS(SLOTS)) dut (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_index(wr_index),
      .wr_data(wr_data), .wr_commit(wr_commit), .wr_len(wr_len), .full(full),
      .wr_overflow(wr_overflow), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(tx_ready), .tx_len(tx_len), .empty(empty)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [IW-1:0] len;
      bit            care;
   } exp_t;

   exp_t          sb_q[$];
   exp_t          mon_e;
   int            vectors     = 0;
   int            miscompares = 0;
   int            ready_mode  = 0;
   int            ready_cyc   = 0;
   logic [DW-1:0] open_mem [DEPTH];
   bit            open_set [DEPTH];
   int            open_len    = 0;
   bit            held        = 1'b0;
   bit            gap_pending = 1'b0;
   logic [DW-1:0] h_data;
   logic          h_last;
   logic [IW-1:0] h_len;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // tx_ready pattern: 0 = held low, 1 = held high, 2 = high one cycle in three
   always @(posedge clock) begin
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b0;
         1:       tx_ready = 1'b1;
         default: tx_ready = ((ready_cyc % 3) == 0);
      endcase
      ready_cyc++;
   end

   // Monitor: scoreboard pop on handshake, stall stability, gap after last word
   always @(negedge clock) begin
      if (reset) begin
         held        = 1'b0;
         gap_pending = 1'b0;
      end else begin
         if (gap_pending) begin
            check("gap_after_last", 64'(tx_valid), 64'd0);
            gap_pending = 1'b0;
         end
         if (held) begin
            check("stall_data", 64'(tx_data), 64'(h_data));
            check("stall_last", 64'(tx_last), 64'(h_last));
            check("stall_len",  64'(tx_len),  64'(h_len));
         end
         held = 1'b0;
         if (tx_valid && tx_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.care) check("tx_data", 64'(tx_data), 64'(mon_e.data));
               check("tx_last", 64'(tx_last), 64'(mon_e.last));
               check("tx_len",  64'(tx_len),  64'(mon_e.len));
            end
            if (tx_last) gap_pending = 1'b1;
         end else if (tx_valid) begin
            held   = 1'b1;
            h_data = tx_data;
            h_last = tx_last;
            h_len  = tx_len;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_open();
      open_len = 0;
      for (int i = 0; i < DEPTH; i++) open_set[i] = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [DW-1:0] d);
      wr_en    = 1'b1;
      wr_index = IW'(idx);
      wr_data  = d;
      if (idx < DEPTH) begin
         open_mem[idx] = d;
         open_set[idx] = 1'b1;
         if (idx + 1 > open_len) open_len = idx + 1;
      end
      tick();
      wr_en = 1'b0;
   endtask

   task automatic commit(input bit accept);
      if (accept && open_len > 0) begin
`ifdef BUFFER_TX_LEN_HEADER_EN
         sb_q.push_back('{DW'(open_len), 1'b0, IW'(open_len), 1'b1});
`endif
         for (int i = 0; i < open_len; i++) begin
            sb_q.push_back('{open_mem[i], (i == open_len - 1) ? 1'b1 : 1'b0,
                             IW'(open_len), open_set[i]});
         end
         clear_open();
      end
      wr_commit = 1'b1;
      tick();
      wr_commit = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (empty && sb_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check("idle_timeout", 64'(done), 64'd1);
      check("empty_idle", 64'(empty), 64'd1);
      tick();
   endtask

   task automatic send_pair(input bit lat_chk);
      for (int i = 0; i < 8; i++) wr(i, DW'(300 + i));
      commit(1'b1);
      if (lat_chk) begin
         @(negedge clock); check("first_valid_e0", 64'(tx_valid), 64'd0);
         @(negedge clock); check("first_valid_e1", 64'(tx_valid), 64'd0);
         @(negedge clock); check("first_valid_e2", 64'(tx_valid), 64'd1);
         tick();
      end
      for (int i = 0; i < 4; i++) wr(i, DW'(400 + i));
      commit(1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit ok;
      reset     = 1'b1;
      wr_en     = 1'b0;
      wr_index  = '0;
      wr_data   = '0;
      wr_commit = 1'b0;
      clear_open();
      #2;
      check("rst_tx_valid",    64'(tx_valid),    64'd0);
      check("rst_tx_last",     64'(tx_last),     64'd0);
      check("rst_tx_data",     64'(tx_data),     64'd0);
      check("rst_tx_len",      64'(tx_len),      64'd0);
      check("rst_wr_len",      64'(wr_len),      64'd0);
      check("rst_full",        64'(full),        64'd0);
      check("rst_wr_overflow", 64'(wr_overflow), 64'd0);
      check("rst_empty",       64'(empty),       64'd1);
      tick();
      reset = 1'b0;

      // Two packets, consumer always ready
      ready_mode = 1;
      send_pair(1'b1);
      wait_idle();

      // Same traffic with a stalling consumer
      ready_mode = 2;
      send_pair(1'b0);
      wait_idle();

      // Fill all committed slots, refused commit, then retry after one drains
      ready_mode = 0;
      for (int k = 0; k < 3; k++) begin
         wr(0, DW'(500 + k));
         commit(1'b1);
      end
      check("full_set", 64'(full), 64'd1);
      wr(0, DW'(503));
      commit(1'b0);
      check("ovf_on_full", 64'(wr_overflow), 64'd1);
      check("len_kept",    64'(wr_len),      64'd1);
      tick();
      check("ovf_pulse_end", 64'(wr_overflow), 64'd0);
      ready_mode = 1;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!full) begin
            ok = 1'b1;
            break;
         end
      end
      check("full_release", 64'(ok), 64'd1);
      commit(1'b1);
      check("retry_accepted", 64'(wr_len), 64'd0);
      wait_idle();

      // Out-of-order writes, bad index, zero-length commit
      wr(5, DW'(605));
      wr(2, DW'(602));
      check("len_out_of_order", 64'(wr_len), 64'd6);
      commit(1'b1);
      wait_idle();
      wr(0, DW'(900));
      wr(16, DW'(901));
      check("ovf_bad_index", 64'(wr_overflow), 64'd1);
      check("len_bad_index", 64'(wr_len),      64'd1);
      commit(1'b1);
      wait_idle();
      commit(1'b1);
      check("len0_no_ovf", 64'(wr_overflow), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("len0_no_tx", 64'(tx_valid), 64'd0);
      end
      tick();

      // Reset in the middle of a packet, then clean traffic
      for (int i = 0; i < 4; i++) wr(i, DW'(700 + i));
      commit(1'b1);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (tx_valid && tx_data == DW'(702)) begin
            ok = 1'b1;
            break;
         end
      end
      check("reach_third_word", 64'(ok), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_tx_valid", 64'(tx_valid), 64'd0);
      check("midrst_tx_last",  64'(tx_last),  64'd0);
      check("midrst_empty",    64'(empty),    64'd1);
      check("midrst_wr_len",   64'(wr_len),   64'd0);
      sb_q.delete();
      clear_open();
      tick();
      reset = 1'b0;
      wr(0, DW'(800));
      wr(1, DW'(801));
      commit(1'b1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
